dfi_phy_loopback: RTL and testbench

DFI_PHY_LOOPBACK -- requirements
Module: dfi_phy_loopback

---
 rtl/dfi_pkg.sv | 18 +
 rtl/dfi_phy_fifo.sv | 78 +++++++
 rtl/dfi_phy_loopback.sv | 201 ++++++++++++++++++++
 tb/tb_dfi_phy_loopback.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfi_pkg.sv
// dfi_pkg: shared init FSM state type and default timing constants for the
// DFI PHY loopback model.
package dfi_pkg;

  // Init sequencing states of the PHY model
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } init_state_e;

  // Default latencies and sizes
  localparam int DFI_TPHY_WRDATA_DEF = 1;
  localparam int DFI_TPHY_RDLAT_DEF  = 4;
  localparam int DFI_INIT_CYCLES_DEF = 16;
  localparam int DFI_FIFO_DEPTH_DEF  = 16;

endpackage

// File: rtl/dfi_phy_fifo.sv
// dfi_phy_fifo: synchronous FIFO holding loopback write data.
// Registered read port; a pop on empty returns zero and flags underflow,
// a push on full without a same-cycle pop is dropped and flags overflow.
module dfi_phy_fifo
  import dfi_pkg::*;
#(
  parameter int C_WIDTH = 64,
  parameter int C_DEPTH = DFI_FIFO_DEPTH_DEF
) (
  input  logic               core_clk,
  input  logic               core_rst,
  input  logic               push,
  input  logic [C_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [C_WIDTH-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int AW = $clog2(C_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(C_DEPTH);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic [C_WIDTH-1:0] rdata_reg;
  logic               do_push;
  logic               do_pop;

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  // A pop frees a slot in the same cycle, so a push on full still fits when
  // paired with a pop; a pop on empty never sees a same-cycle push.
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | pop);
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;
  assign pop_data  = rdata_reg;

  // Storage write port
  always_ff @(posedge core_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read port; anything other than a successful pop yields zero
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rdata_reg <= '0;
    end else if (do_pop) begin
      rdata_reg <= mem[rd_ptr_reg];
    end else begin
      rdata_reg <= '0;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dfi_phy_loopback.sv
// dfi_phy_loopback: DFI PHY model that loops write data back as read data.
// Optional feature macro: DFI_PHY_CTRLUPD_EN enables the controller-update
// acknowledge handshake; when undefined the acknowledge is tied low.
module dfi_phy_loopback
  import dfi_pkg::*;
#(
  parameter int C_DFI_DATA_WIDTH   = 64,
  parameter int C_DFI_DM_WIDTH     = 8,
  parameter int C_DFI_DATAEN_WIDTH = 4,
  parameter int C_TPHY_WRDATA      = DFI_TPHY_WRDATA_DEF,
  parameter int C_TPHY_RDLAT       = DFI_TPHY_RDLAT_DEF,
  parameter int C_INIT_CYCLES      = DFI_INIT_CYCLES_DEF,
  parameter int C_FIFO_DEPTH       = DFI_FIFO_DEPTH_DEF
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic                          dfi_init_start,
  output logic                          dfi_init_complete,
  input  logic [C_DFI_DATAEN_WIDTH-1:0] dfi_wrdata_en,
  input  logic [C_DFI_DATA_WIDTH-1:0]   dfi_wrdata,
  input  logic [C_DFI_DM_WIDTH-1:0]     dfi_wrdata_mask,
  input  logic [C_DFI_DATAEN_WIDTH-1:0] dfi_rddata_en,
  output logic [C_DFI_DATA_WIDTH-1:0]   dfi_rddata,
  output logic [C_DFI_DATAEN_WIDTH-1:0] dfi_rddata_valid,
  input  logic                          dfi_ctrlupd_req,
  output logic                          dfi_ctrlupd_ack,
  output logic                          dfi_error
);

  localparam int CNT_W = $clog2(C_INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_INIT_CYCLES - 1);

  genvar gi;

  init_state_e              state_reg;
  init_state_e              state_next;
  logic [CNT_W-1:0]         cnt_reg;
  logic [CNT_W-1:0]         cnt_next;
  logic                     ready;

  logic                     wr_accept;
  logic                     rd_accept;
  logic                     wr_pipe_reg [C_TPHY_WRDATA];
  logic [C_DFI_DATA_WIDTH-1:0] wr_masked;
  logic                     fifo_push;
  logic [C_DFI_DATA_WIDTH-1:0] fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_overflow;
  logic                     fifo_underflow;
  logic                     rd_vld_reg  [C_TPHY_RDLAT];
  logic [C_DFI_DATA_WIDTH-1:0] rd_data_reg [C_TPHY_RDLAT-1];
  logic                     rd_vld_out;

  // Init state and counter registers
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Init next-state: the IDLE cycle that samples init_start counts as init cycle one
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (dfi_init_start) begin
          state_next = ST_INIT;
          cnt_next   = CNT_ONE;
        end
      end
      ST_INIT: begin
        if (!dfi_init_start) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Init outputs: traffic is only honoured once the PHY reports ready
  always_comb begin
    ready             = 1'b0;
    dfi_init_complete = 1'b0;
    if (state_reg == ST_READY) begin
      ready             = 1'b1;
      dfi_init_complete = 1'b1;
    end
  end

  assign wr_accept = ready & (|dfi_wrdata_en);
  assign rd_accept = ready & (|dfi_rddata_en);

  // Write-enable delay line: data and mask arrive C_TPHY_WRDATA cycles later
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      for (int i = 0; i < C_TPHY_WRDATA; i++) begin
        wr_pipe_reg[i] <= 1'b0;
      end
    end else begin
      wr_pipe_reg[0] <= wr_accept;
      for (int i = 1; i < C_TPHY_WRDATA; i++) begin
        wr_pipe_reg[i] <= wr_pipe_reg[i-1];
      end
    end
  end

  assign fifo_push = wr_pipe_reg[C_TPHY_WRDATA-1];

  // Masked bytes are stored as zero
  generate
    for (gi = 0; gi < C_DFI_DM_WIDTH; gi++) begin : g_mask
      assign wr_masked[gi*8 +: 8] = dfi_wrdata_mask[gi] ? 8'h00 : dfi_wrdata[gi*8 +: 8];
    end
  endgenerate

  dfi_phy_fifo #(
    .C_WIDTH (C_DFI_DATA_WIDTH),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .push      (fifo_push),
    .push_data (wr_masked),
    .pop       (rd_accept),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow),
    .underflow (fifo_underflow)
  );

  // Read latency line: the FIFO read register is the first data stage, so the
  // data line is one stage shorter than the valid line
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      for (int i = 0; i < C_TPHY_RDLAT; i++) begin
        rd_vld_reg[i] <= 1'b0;
      end
      for (int i = 0; i < C_TPHY_RDLAT - 1; i++) begin
        rd_data_reg[i] <= '0;
      end
    end else begin
      rd_vld_reg[0]  <= rd_accept;
      rd_data_reg[0] <= rd_vld_reg[0] ? fifo_rdata : '0;
      for (int i = 1; i < C_TPHY_RDLAT; i++) begin
        rd_vld_reg[i] <= rd_vld_reg[i-1];
      end
      for (int i = 1; i < C_TPHY_RDLAT - 1; i++) begin
        rd_data_reg[i] <= rd_data_reg[i-1];
      end
    end
  end

  assign rd_vld_out       = rd_vld_reg[C_TPHY_RDLAT-1];
  assign dfi_rddata_valid = {C_DFI_DATAEN_WIDTH{rd_vld_out}};
  assign dfi_rddata       = rd_vld_out ? rd_data_reg[C_TPHY_RDLAT-2] : '0;
  assign dfi_error        = fifo_overflow | fifo_underflow;

`ifdef DFI_PHY_CTRLUPD_EN
  logic ctrlupd_ack_reg;

  // Acknowledge mirrors the request one cycle later while ready
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      ctrlupd_ack_reg <= 1'b0;
    end else begin
      ctrlupd_ack_reg <= ready & dfi_ctrlupd_req;
    end
  end

  assign dfi_ctrlupd_ack = ctrlupd_ack_reg;
`else
  logic ctrlupd_unused;

  assign ctrlupd_unused  = dfi_ctrlupd_req;
  assign dfi_ctrlupd_ack = 1'b0;
`endif

  logic fifo_flags_unused;
  assign fifo_flags_unused = fifo_full ^ fifo_empty;

endmodule

// File: tb/tb_dfi_phy_loopback.sv
// tb_dfi_phy_loopback: randomized scoreboard bench for dfi_phy_loopback.
// Stimulus updates a queue-based model; a negedge monitor checks outputs.
module tb_dfi_phy_loopback;

  localparam int DW    = 64;
  localparam int DMW   = 8;
  localparam int ENW   = 4;
  localparam int TWR   = 1;
  localparam int TRL   = 4;
  localparam int INIT  = 16;
  localparam int DEPTH = 16;

  logic           core_clk = 1'b0;
  logic           core_rst;
  logic           dfi_init_start;
  logic           dfi_init_complete;
  logic [ENW-1:0] dfi_wrdata_en;
  logic [DW-1:0]  dfi_wrdata;
  logic [DMW-1:0] dfi_wrdata_mask;
  logic [ENW-1:0] dfi_rddata_en;
  logic [DW-1:0]  dfi_rddata;
  logic [ENW-1:0] dfi_rddata_valid;
  logic           dfi_ctrlupd_req;
  logic           dfi_ctrlupd_ack;
  logic           dfi_error;

  dfi_phy_loopback #(
    .C_DFI_DATA_WIDTH   (DW),
    .C_DFI_DM_WIDTH     (DMW),
    .C_DFI_DATAEN_WIDTH (ENW),
    .C_TPHY_WRDATA      (TWR),
    .C_TPHY_RDLAT       (TRL),
    .C_INIT_CYCLES      (INIT),
    .C_FIFO_DEPTH       (DEPTH)
  ) dut (
    .core_clk          (core_clk),
    .core_rst          (core_rst),
    .dfi_init_start    (dfi_init_start),
    .dfi_init_complete (dfi_init_complete),
    .dfi_wrdata_en     (dfi_wrdata_en),
    .dfi_wrdata        (dfi_wrdata),
    .dfi_wrdata_mask   (dfi_wrdata_mask),
    .dfi_rddata_en     (dfi_rddata_en),
    .dfi_rddata        (dfi_rddata),
    .dfi_rddata_valid  (dfi_rddata_valid),
    .dfi_ctrlupd_req   (dfi_ctrlupd_req),
    .dfi_ctrlupd_ack   (dfi_ctrlupd_ack),
    .dfi_error         (dfi_error)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int             due;
    logic [DW-1:0]  data;
    logic [DMW-1:0] mask;
  } wr_pend_t;

  int            tests = 0;
  int            fails = 0;
  bit            model_ready = 0;
  bit            mon_en = 0;
  logic [DW-1:0] model_fifo [$];
  wr_pend_t      wr_q [$];
  rd_exp_t       rd_q [$];
  int            err_q [$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] apply_mask(logic [DW-1:0] d, logic [DMW-1:0] m);
    logic [DW-1:0] r = d;
    for (int b = 0; b < DMW; b++) begin
      if (m[b]) r[b*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [ENW-1:0] some_lanes();
    return ENW'($urandom_range(1, (1 << ENW) - 1));
  endfunction

  // One cycle of stimulus; the model applies pop before push (no bypass)
  task automatic drive_cycle(input bit rd, input bit wr,
                             input logic [DW-1:0] wd, input logic [DMW-1:0] wm);
    bit             have;
    logic [DW-1:0]  d;
    logic [DMW-1:0] m;
    dfi_rddata_en = rd ? some_lanes() : '0;
    dfi_wrdata_en = wr ? some_lanes() : '0;
    have = (wr_q.size() > 0) && (wr_q[0].due == cyc);
    if (have) begin
      d = wr_q[0].data;
      m = wr_q[0].mask;
      void'(wr_q.pop_front());
    end else begin
      d = {$urandom, $urandom};
      m = DMW'($urandom);
    end
    dfi_wrdata      = d;
    dfi_wrdata_mask = m;
    if (model_ready) begin
      if (rd) begin
        if (model_fifo.size() > 0) begin
          rd_q.push_back('{due: cyc + TRL, data: model_fifo.pop_front()});
        end else begin
          rd_q.push_back('{due: cyc + TRL, data: '0});
          err_q.push_back(cyc);
        end
      end
      if (have) begin
        if (model_fifo.size() < DEPTH) model_fifo.push_back(apply_mask(d, m));
        else err_q.push_back(cyc);
      end
      if (wr) wr_q.push_back('{due: cyc + TWR, data: wd, mask: wm});
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic rnd_cycle(input int prd, input int pwr);
    logic [DMW-1:0] m;
    m = (($urandom % 4) == 0) ? DMW'($urandom) : '0;
    drive_cycle(($urandom % 100) < prd, ($urandom % 100) < pwr, {$urandom, $urandom}, m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(0, 0, '0, '0);
  endtask

  task automatic empty_fifo();
    int guard = 0;
    idle(TWR + 1);
    while (model_fifo.size() > 0 && guard < 2 * DEPTH) begin
      drive_cycle(1, 0, '0, '0);
      guard++;
    end
    idle(TRL + 2);
  endtask

  // Runs init with init_start already high this cycle and checks the ready edge
  task automatic run_init(input int n);
    int t0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (cyc - t0 >= INIT) model_ready = 1;
      check("init_complete", 64'(dfi_init_complete), 64'(cyc - t0 >= INIT));
      rnd_cycle(30, 30);
    end
  endtask

  // Monitor: checks error, read response and update acknowledge every cycle
  bit exp_ack = 0;
  initial begin
    rd_exp_t e;
    bit      exp_err;
    forever begin
      @(negedge core_clk);
      if (mon_en) begin
        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        if (exp_err) void'(err_q.pop_front());
        check("dfi_error", 64'(dfi_error), 64'(exp_err));
        check("ctrlupd_ack", 64'(dfi_ctrlupd_ack), 64'(exp_ack));
        if (dfi_rddata_valid != '0) begin
          tests++;
          if (rd_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid @cyc %0d: got valid %h data %h, expected no valid",
                     cyc, dfi_rddata_valid, dfi_rddata);
          end else begin
            e = rd_q.pop_front();
            check("rd_cycle", 64'(cyc), 64'(e.due));
            check("rd_lanes", 64'(dfi_rddata_valid), 64'({ENW{1'b1}}));
            check("rd_data", dfi_rddata, e.data);
          end
        end else begin
          check("rd_idle_zero", dfi_rddata, '0);
          if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_valid @cyc %0d: got no valid, expected data %h due %0d",
                     cyc, rd_q[0].data, rd_q[0].due);
            void'(rd_q.pop_front());
          end
        end
      end
`ifdef DFI_PHY_CTRLUPD_EN
      exp_ack = dfi_ctrlupd_req && model_ready && !core_rst;
`else
      exp_ack = 0;
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    core_rst        = 1;
    dfi_init_start  = 0;
    dfi_wrdata_en   = '0;
    dfi_rddata_en   = '0;
    dfi_wrdata      = '0;
    dfi_wrdata_mask = '0;
    dfi_ctrlupd_req = 0;
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_init_complete", 64'(dfi_init_complete), 64'(0));
    check("rst_valid", 64'(dfi_rddata_valid), 64'(0));
    check("rst_rddata", dfi_rddata, '0);
    check("rst_error", 64'(dfi_error), 64'(0));
    check("rst_ack", 64'(dfi_ctrlupd_ack), 64'(0));

    // Init with an abort; enables before ready must be ignored
    mon_en         = 1;
    core_rst       = 0;
    dfi_init_start = 1;
    for (int i = 0; i < 8; i++) begin
      check("init_abort_low", 64'(dfi_init_complete), 64'(0));
      rnd_cycle(40, 40);
    end
    dfi_init_start = 0;
    check("init_abort_low", 64'(dfi_init_complete), 64'(0));
    rnd_cycle(40, 40);
    dfi_init_start = 1;
    run_init(22);

    // Masked write then read back
    empty_fifo();
    drive_cycle(0, 1, 64'h0123456789ABCDEF, 8'h01);
    idle(3);
    drive_cycle(1, 0, '0, '0);
    idle(TRL + 2);

    // Read on empty
    drive_cycle(1, 0, '0, '0);
    idle(TRL + 2);

    // Fill, overflow on the 17th write, then read all back in order
    for (int i = 1; i <= DEPTH + 1; i++) drive_cycle(0, 1, 64'(i), '0);
    idle(TWR + 2);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 0, '0, '0);
    idle(TRL + 2);

    // Random traffic; init_start toggling while ready is ignored
    for (int i = 0; i < 400; i++) begin
      dfi_init_start  = $urandom % 2;
      dfi_ctrlupd_req = ($urandom % 4) == 0;
      check("ready_holds", 64'(dfi_init_complete), 64'(1));
      rnd_cycle(45, 50);
    end
    dfi_ctrlupd_req = 0;
    empty_fifo();

    // Update request held for three cycles
    dfi_ctrlupd_req = 1;
    idle(3);
    dfi_ctrlupd_req = 0;
    idle(3);

    // Reset two cycles after a read is issued
    drive_cycle(0, 1, 64'hDEADBEEFCAFEF00D, '0);
    idle(2);
    drive_cycle(1, 0, '0, '0);
    idle(1);
    core_rst       = 1;
    dfi_init_start = 0;
    model_ready    = 0;
    rd_q.delete();
    err_q.delete();
    wr_q.delete();
    model_fifo.delete();
    idle(2);
    core_rst = 0;
    for (int i = 0; i < 12; i++) begin
      check("post_rst_complete", 64'(dfi_init_complete), 64'(0));
      idle(1);
    end

    // Clean init from reset, then traffic on the freshly emptied FIFO
    dfi_init_start = 1;
    run_init(20);
    for (int i = 0; i < 60; i++) rnd_cycle(50, 50);
    empty_fifo();
    idle(4);

    if (rd_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_reads: got %0d pending, expected 0", rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
